mux41_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 select path. Four requesters present data on `in0`..`in3`. The block grants one requester at a time, drives the `s1:s0` select of the two-level 4:1 mux tree, and moves the selected word into a registered output stage with a valid/ready handshake. A grant is held for bursts of up to `MAX_BURST` beats, so the output is shared fairly.

---
 rtl/mux41_arb_pkg.sv | 21 ++
 rtl/mux41_sel.sv | 21 ++
 rtl/mux41_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux41_arb_pkg.sv
// Shared types and the round-robin pick helper for the 4:1 select arbiter.
package mux41_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE, GRANT} state_t;
  typedef logic [1:0] idx_t;

  // First set request bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] req, input idx_t ptr);
    idx_t pick;
    idx_t cand;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + idx_t'(k);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux41_sel.sv
// Two-level 4:1 select tree: s0 picks within each pair, s1 picks the pair.
module mux41_sel #(
  parameter int DATA_WIDTH = 1
) (
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic                  s0,
  input  logic                  s1,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH-1:0] mux1;
  logic [DATA_WIDTH-1:0] mux2;

  assign mux1 = s0 ? in1 : in0;
  assign mux2 = s0 ? in3 : in2;
  assign y    = s1 ? mux2 : mux1;

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin burst arbiter feeding a shared 4:1 select path into a
// registered valid/ready output stage.
//
// state | meaning
// IDLE  | no grant; picks next requester from ptr when any req is set
// GRANT | {s1,s0} owns the path; moves one beat per cycle when output is free
module mux41_rr_arbiter
  import mux41_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  s0,
  output logic                  s1,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  state_t                state_q, state_d;
  idx_t                  ptr_q, ptr_d;
  idx_t                  sel_q, sel_d;
  idx_t                  pick;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  free;
  logic                  xfer;

  mux41_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .s0  (sel_q[0]),
    .s1  (sel_q[1]),
    .y   (sel_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      burst_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      burst_q   <= burst_d;
      out_valid <= valid_d;
      out_data  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    valid_d = out_valid;
    data_d  = out_data;
    xfer    = 1'b0;
    free    = !out_valid || out_ready;
    pick    = rr_pick(req, ptr_q);

    if (out_valid && out_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = NUM_REQ'(1) << pick;
          sel_d   = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
          gnt_d   = '0;
        end else if (free) begin
          // a pop in this same cycle is overridden by the new load
          xfer    = 1'b1;
          valid_d = 1'b1;
          data_d  = sel_word;
          burst_d = burst_q + 1'b1;
          if (burst_q == LAST_BEAT) begin
            state_d = IDLE;
            ptr_d   = sel_q + 2'd1;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack = xfer ? gnt_q : '0;
  assign gnt = gnt_q;
  assign s0  = sel_q[0];
  assign s1  = sel_q[1];

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed and randomized checks of the round-robin arbiter against a
// transaction-level model and an output scoreboard.
module tb_mux41_rr_arbiter;

  localparam int DW   = 8;
  localparam int MAXB = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          req = '0;
  logic [3:0][DW-1:0]  din = '0;
  logic                out_ready = 1'b0;
  logic [3:0]          ack;
  logic [3:0]          gnt;
  logic                s0;
  logic                s1;
  logic                out_valid;
  logic [DW-1:0]       out_data;

  always #5 clk = ~clk;

  mux41_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .ack       (ack),
    .gnt       (gnt),
    .s0        (s0),
    .s1        (s1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: who owns the path, where the rotation resumes, output register
  bit            m_busy;
  int            m_g;
  int            m_ptr;
  int            m_beats;
  bit            m_ov;
  logic [DW-1:0] m_od;
  logic [DW-1:0] sb[$];
  logic [3:0]    trace[$];
  bit            rand_mode = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_ack();
    if (m_busy && req[m_g] && (!m_ov || out_ready)) return 4'b0001 << m_g;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_g = 0; m_ptr = 0; m_beats = 0;
    m_ov = 1'b0; m_od = '0;
    sb.delete();
  endtask

  task automatic model_advance(input logic [3:0] a);
    bit found;
    int idx;
    if (m_ov && out_ready) m_ov = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!found && req[idx]) begin
          found = 1'b1;
          m_g = idx;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_beats = 0;
      end
    end else if (!req[m_g]) begin
      m_busy = 1'b0;
      m_ptr = (m_g + 1) % 4;
    end else if (a != 4'b0000) begin
      m_ov = 1'b1;
      m_od = din[m_g];
      sb.push_back(din[m_g]);
      m_beats++;
      if (m_beats == MAXB) begin
        m_busy = 1'b0;
        m_ptr = (m_g + 1) % 4;
      end
    end
  endtask

  task automatic drive_next(input logic [3:0] a);
    for (int i = 0; i < 4; i++) begin
      if (a[i]) din[i] = DW'($urandom);
      if (rand_mode) begin
        if (a[i]) req[i] = 1'($urandom % 2);
        else if (!req[i]) begin
          req[i] = ($urandom % 3 == 0);
          din[i] = DW'($urandom);
        end
      end
    end
    if (rand_mode) out_ready = ($urandom % 4 != 0);
  endtask

  task automatic cycle();
    logic [3:0] a;
    logic [DW-1:0] w;
    @(negedge clk);
    a = exp_ack();
    check_val("ack", 32'(ack), 32'(a));
    check_val("gnt", 32'(gnt), 32'(m_busy ? (4'b0001 << m_g) : 4'b0000));
    if (m_busy) check_val("sel", 32'({s1, s0}), 32'(m_g));
    check_val("out_valid", 32'(out_valid), 32'(m_ov));
    check_val("out_data", 32'(out_data), 32'(m_od));
    if (out_valid && out_ready) begin
      check_val("sb_nonempty", 32'(sb.size() > 0), 32'(1));
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check_val("sb_word", 32'(out_data), 32'(w));
      end
    end
    trace.push_back(ack);
    model_advance(a);
    @(posedge clk);
    #1;
    drive_next(a);
  endtask

  task automatic reset_outputs_zero();
    check_val("rst_ack", 32'(ack), 32'(0));
    check_val("rst_gnt", 32'(gnt), 32'(0));
    check_val("rst_sel", 32'({s1, s0}), 32'(0));
    check_val("rst_valid", 32'(out_valid), 32'(0));
    check_val("rst_data", 32'(out_data), 32'(0));
  endtask

  // called at posedge+1; asserts reset between edges to exercise the async path
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 reset_outputs_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] exp_rot [14] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                                 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    logic [3:0] exp_wrap [6] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4};
    logic [DW-1:0] w;
    int n_ack;
    int n_ack2;

    for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
    #3 reset_outputs_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // fair rotation, one bubble per grant change
    req = 4'b1111; out_ready = 1'b1; trace.delete();
    repeat (14) cycle();
    for (int i = 0; i < 14; i++) check_val($sformatf("rot%0d", i), 32'(trace[i]), 32'(exp_rot[i]));

    // reset mid-burst, then first grant to requester 0
    do_reset();
    trace.delete();
    repeat (2) cycle();
    check_val("post_rst_first", 32'(trace[1]), 32'(4'b0001));

    // pointer wrap: after granting 2, {0,2} requests go 0 then 2
    do_reset();
    req = 4'b0100; trace.delete();
    repeat (3) cycle();
    req = 4'b0101; trace.delete();
    repeat (6) cycle();
    for (int i = 0; i < 6; i++) check_val($sformatf("wrap%0d", i), 32'(trace[i]), 32'(exp_wrap[i]));

    // backpressure: one beat lands, grant held, output frozen, then resumes
    do_reset();
    req = 4'b0001; out_ready = 1'b0; trace.delete();
    cycle();
    w = din[0];
    cycle();
    repeat (5) begin
      cycle();
      check_val("bp_stable", 32'(out_data), 32'(w));
    end
    n_ack = 0;
    foreach (trace[i]) if (trace[i] != 4'b0000) n_ack++;
    check_val("bp_ack_count", 32'(n_ack), 32'(1));
    out_ready = 1'b1;
    repeat (3) cycle();
    check_val("bp_resume", 32'(trace[7]), 32'(4'b0001));

    // early release by requester 2 moves the pointer to 3
    do_reset();
    req = 4'b0100; out_ready = 1'b1; trace.delete();
    repeat (2) cycle();
    req = 4'b0000;
    cycle();
    req = 4'b1111;
    repeat (6) cycle();
    check_val("er_first", 32'(trace[1]), 32'(4'b0100));
    n_ack2 = 0;
    for (int i = 2; i < trace.size(); i++) if (trace[i][2]) n_ack2++;
    check_val("er_no_ack2", 32'(n_ack2), 32'(0));
    check_val("er_next3", 32'(trace[4]), 32'(4'b1000));

    // random traffic and backpressure
    do_reset();
    rand_mode = 1'b1; req = '0;
    repeat (3000) cycle();
    check_val("sb_left", 32'(sb.size()), 32'(m_ov));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
